// File: rtl/accumulation_ctrl_mc.sv
// accumulation_ctrl_mc
// Multi-channel accumulation controller for the Mage access path. Each
// channel compares one IV of one hwlp register-file entry against a
// programmed constraint and issues a match to Mage after a programmable
// delay. A second, independently delayed copy of that match is ORed with a
// delayed one-shot start pulse and goes to the PEA accumulator.
//
// Optional build macro:
//   ACC_CTRL_MATCH_CNT_EN - adds per-channel saturating match counters and
//                           the match_cnt_o port.
//
// Default parameter values follow the Mage hwlp configuration
// (4 entries x 4 IVs x 8 bit).
module accumulation_ctrl_mc #(
    parameter int N_CH              = 4,
    parameter int HWLP_RF_SIZE      = 4,
    parameter int N_LP              = 4,
    parameter int NBIT_LP_IV        = 8,
    parameter int MAX_DLY           = 8,
    parameter int CNT_W             = 16,
    parameter int LOG2_HWLP_RF_SIZE = (HWLP_RF_SIZE > 1) ? $clog2(HWLP_RF_SIZE) : 1,
    parameter int LOG2_N_LP         = (N_LP > 1) ? $clog2(N_LP) : 1,
    parameter int DLY_W             = $clog2(MAX_DLY)
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_n_i,
    input  logic [HWLP_RF_SIZE-1:0][N_LP-1:0][NBIT_LP_IV-1:0]      hwlp_rf_i,
    input  logic [HWLP_RF_SIZE-1:0]                                hwlp_valid_i,
    input  logic [N_CH-1:0]                                        reg_en_i,
    input  logic [N_CH-1:0]                                        reg_edge_i,
    input  logic [N_CH-1:0][LOG2_HWLP_RF_SIZE-1:0]                 reg_hwlp_sel_i,
    input  logic [N_CH-1:0][LOG2_N_LP-1:0]                         reg_iv_sel_i,
    input  logic [N_CH-1:0][NBIT_LP_IV-1:0]                        reg_iv_constraint_i,
    input  logic [N_CH-1:0][DLY_W-1:0]                             reg_mage_dly_i,
    input  logic [N_CH-1:0][DLY_W-1:0]                             reg_pea_dly_i,
    input  logic [N_CH-1:0][DLY_W-1:0]                             reg_start_dly_i,
    output logic [N_CH-1:0]                                        match_o,
`ifdef ACC_CTRL_MATCH_CNT_EN
    output logic [N_CH-1:0][CNT_W-1:0]                             match_cnt_o,
`endif
    output logic [N_CH-1:0]                                        match_d_o
);

    if (MAX_DLY < 2 || (1 << DLY_W) != MAX_DLY) begin : g_bad_max_dly
        $error("accumulation_ctrl_mc: MAX_DLY must be a power of 2 and >= 2");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch

        // state | meaning
        // IDLE  | entry not valid or channel disabled, waiting for a run
        // START | first cycle after en & valid rose, start pulse is high
        // RUN   | run in progress, no further start pulse
        typedef enum logic [1:0] {
            ST_IDLE  = 2'd0,
            ST_START = 2'd1,
            ST_RUN   = 2'd2
        } state_t;

        state_t                  state_q;
        logic                    en;
        logic                    valid;
        logic                    run_ok;
        logic [NBIT_LP_IV-1:0]   iv;
        logic                    hit;
        logic                    hit_q;
        logic                    raw;
        logic                    start;
        logic [MAX_DLY-1:1]      mage_sr;
        logic [MAX_DLY-1:1]      pea_sr;
        logic [MAX_DLY-1:1]      start_sr;
        logic [MAX_DLY-1:0]      mage_tap;
        logic [MAX_DLY-1:0]      pea_tap;
        logic [MAX_DLY-1:0]      start_tap;

        assign en     = reg_en_i[c];
        assign valid  = hwlp_valid_i[reg_hwlp_sel_i[c]];
        assign iv     = hwlp_rf_i[reg_hwlp_sel_i[c]][reg_iv_sel_i[c]];
        assign run_ok = en & valid;

        // Constraint compare and edge qualification. The hit is also gated
        // by reset so a zero-delay tap cannot leak a match while in reset.
        always_comb begin
            hit = rst_n_i & en & valid & (iv == reg_iv_constraint_i[c]);
            raw = reg_edge_i[c] ? (hit & ~hit_q) : hit;
        end

        // Tap 0 of every line is the undelayed input; tap k is k cycles late.
        assign mage_tap  = {mage_sr, raw};
        assign match_o[c] = mage_tap[reg_mage_dly_i[c]];

        assign start     = (state_q == ST_START);
        assign pea_tap   = {pea_sr, match_o[c]};
        assign start_tap = {start_sr, start};
        assign match_d_o[c] = pea_tap[reg_pea_dly_i[c]] | start_tap[reg_start_dly_i[c]];

        // Edge history and the three delay lines; disabling flushes them.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                hit_q    <= 1'b0;
                mage_sr  <= '0;
                pea_sr   <= '0;
                start_sr <= '0;
            end else if (!en) begin
                hit_q    <= 1'b0;
                mage_sr  <= '0;
                pea_sr   <= '0;
                start_sr <= '0;
            end else begin
                hit_q    <= hit;
                mage_sr  <= mage_tap[MAX_DLY-2:0];
                pea_sr   <= pea_tap[MAX_DLY-2:0];
                start_sr <= start_tap[MAX_DLY-2:0];
            end
        end

        // Start sequencer: one START cycle per run of en & valid.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:  state_q <= run_ok ? ST_START : ST_IDLE;
                    ST_START: state_q <= run_ok ? ST_RUN   : ST_IDLE;
                    ST_RUN:   state_q <= run_ok ? ST_RUN   : ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end

`ifdef ACC_CTRL_MATCH_CNT_EN
        logic [CNT_W-1:0] cnt_q;

        // Saturating count of cycles with match_o high, cleared on disable.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                cnt_q <= '0;
            end else if (!en) begin
                cnt_q <= '0;
            end else if (match_o[c] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign match_cnt_o[c] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_accumulation_ctrl_mc.sv
// Directed bench for accumulation_ctrl_mc: a vector table for the main
// single-channel sweep plus hand-written multi-cycle sequences.
module tb_accumulation_ctrl_mc;

    localparam int N_CH = 4;
    localparam int HW   = 4;
    localparam int NLP  = 4;
    localparam int NB   = 8;
    localparam int MD   = 8;
    localparam int CW   = 2;
    localparam int DW   = 3;

    logic                            clk_i = 1'b0;
    logic                            rst_n_i;
    logic [HW-1:0][NLP-1:0][NB-1:0]  hwlp_rf;
    logic [HW-1:0]                   hwlp_valid;
    logic [N_CH-1:0]                 en;
    logic [N_CH-1:0]                 edg;
    logic [N_CH-1:0][1:0]            hsel;
    logic [N_CH-1:0][1:0]            isel;
    logic [N_CH-1:0][NB-1:0]         cons;
    logic [N_CH-1:0][DW-1:0]         mdly;
    logic [N_CH-1:0][DW-1:0]         pdly;
    logic [N_CH-1:0][DW-1:0]         sdly;
    logic [N_CH-1:0]                 match;
    logic [N_CH-1:0]                 match_d;
`ifdef ACC_CTRL_MATCH_CNT_EN
    logic [N_CH-1:0][CW-1:0]         cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    accumulation_ctrl_mc #(
        .N_CH(N_CH), .HWLP_RF_SIZE(HW), .N_LP(NLP), .NBIT_LP_IV(NB),
        .MAX_DLY(MD), .CNT_W(CW)
    ) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .hwlp_rf_i           (hwlp_rf),
        .hwlp_valid_i        (hwlp_valid),
        .reg_en_i            (en),
        .reg_edge_i          (edg),
        .reg_hwlp_sel_i      (hsel),
        .reg_iv_sel_i        (isel),
        .reg_iv_constraint_i (cons),
        .reg_mage_dly_i      (mdly),
        .reg_pea_dly_i       (pdly),
        .reg_start_dly_i     (sdly),
        .match_o             (match),
`ifdef ACC_CTRL_MATCH_CNT_EN
        .match_cnt_o         (cnt),
`endif
        .match_d_o           (match_d)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NB-1:0]   iv;
        logic            valid;
        logic [N_CH-1:0] exp_m;
        logic [N_CH-1:0] exp_d;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 3 ns later.
    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_cfg();
        hwlp_rf    = '0;
        hwlp_valid = '0;
        en         = '0;
        edg        = '0;
        hsel       = '0;
        isel       = '0;
        cons       = '0;
        mdly       = '0;
        pdly       = '0;
        sdly       = '0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        clear_cfg();
        repeat (2) next_cyc();
        rst_n_i = 1'b1;
    endtask

    task automatic run_edge(input logic e, input int exp_pulses);
        int pulses;
        pulses = 0;
        do_reset();
        en[1] = 1'b1; edg[1] = e; hsel[1] = 2'd2; isel[1] = 2'd1; cons[1] = 8'd5;
        for (int t = 0; t < 10; t++) begin
            hwlp_rf[2][1] = (t >= 3 && t <= 6) ? 8'd5 : 8'd0;
            hwlp_valid[2] = 1'b1;
            #3;
            if (match[1]) pulses++;
            if (t == 3) begin
                chk($sformatf("edge%0d_dly0_same_cycle", e), 32'(match[1]), 32'd1);
                chk($sformatf("edge%0d_pea0_same_cycle", e), 32'(match_d[1]), 32'd1);
            end
            next_cyc();
        end
        chk($sformatf("edge%0d_pulse_count", e), 32'(pulses), 32'(exp_pulses));
    endtask

    task automatic run_dual(input logic kill);
        do_reset();
        en[0] = 1'b1; hsel[0] = 2'd0; isel[0] = 2'd2; cons[0] = 8'd3; mdly[0] = 3'd1;
        en[2] = 1'b1; hsel[2] = 2'd0; isel[2] = 2'd2; cons[2] = 8'd3; mdly[2] = 3'd6;
        for (int t = 0; t < 12; t++) begin
            if (kill && t == 5) en[2] = 1'b0;
            hwlp_rf[0][2] = (t == 2) ? 8'd3 : 8'd0;
            hwlp_valid[0] = 1'b1;
            #3;
            chk($sformatf("dual%0d_ch0_t%0d", kill, t), 32'(match[0]), 32'(t == 3));
            chk($sformatf("dual%0d_ch2_t%0d", kill, t), 32'(match[2]), 32'(!kill && t == 8));
            next_cyc();
        end
    endtask

    initial begin
        int first;
        int pulses;

        // IV = t mod 8, hit at t=5; match_o at 6, PEA copy at 10, start at 1 -> 3.
        vecs[0]  = '{8'd0, 1'b1, 4'h0, 4'h0};
        vecs[1]  = '{8'd1, 1'b1, 4'h0, 4'h0};
        vecs[2]  = '{8'd2, 1'b1, 4'h0, 4'h0};
        vecs[3]  = '{8'd3, 1'b1, 4'h0, 4'h1};
        vecs[4]  = '{8'd4, 1'b1, 4'h0, 4'h0};
        vecs[5]  = '{8'd5, 1'b1, 4'h0, 4'h0};
        vecs[6]  = '{8'd6, 1'b1, 4'h1, 4'h0};
        vecs[7]  = '{8'd7, 1'b1, 4'h0, 4'h0};
        vecs[8]  = '{8'd0, 1'b1, 4'h0, 4'h0};
        vecs[9]  = '{8'd1, 1'b1, 4'h0, 4'h0};
        vecs[10] = '{8'd2, 1'b1, 4'h0, 4'h1};
        vecs[11] = '{8'd3, 1'b1, 4'h0, 4'h0};

        // Reset state, with a zero-delay channel whose compare would hit.
        rst_n_i = 1'b0;
        clear_cfg();
        en[0] = 1'b1;
        hwlp_valid = '1;
        #3;
        chk("reset_match_o", 32'(match), 32'd0);
        chk("reset_match_d_o", 32'(match_d), 32'd0);
`ifdef ACC_CTRL_MATCH_CNT_EN
        chk("reset_cnt", 32'(cnt), 32'd0);
`endif

        // Main sweep on ch0.
        do_reset();
        en[0] = 1'b1; hsel[0] = 2'd1; isel[0] = 2'd0; cons[0] = 8'd5;
        mdly[0] = 3'd1; pdly[0] = 3'd4; sdly[0] = 3'd2;
        for (int t = 0; t < 12; t++) begin
            hwlp_rf[1][0] = vecs[t].iv;
            hwlp_valid[1] = vecs[t].valid;
            #3;
            chk($sformatf("sweep_match_o_t%0d", t), 32'(match), 32'(vecs[t].exp_m));
            chk($sformatf("sweep_match_d_o_t%0d", t), 32'(match_d), 32'(vecs[t].exp_d));
            next_cyc();
        end

        // Edge mode: one pulse for a 4-cycle hold; level mode: four pulses.
        run_edge(1'b1, 1);
        run_edge(1'b0, 4);

        // Maximum Mage delay.
        do_reset();
        en[1] = 1'b1; hsel[1] = 2'd2; isel[1] = 2'd1; cons[1] = 8'd5; mdly[1] = 3'd7;
        first = -1;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            hwlp_rf[2][1] = (t == 2) ? 8'd5 : 8'd0;
            hwlp_valid[2] = 1'b1;
            #3;
            if (match[1]) begin
                pulses++;
                if (first < 0) first = t;
            end
            next_cyc();
        end
        chk("mage_dly7_latency", 32'(first - 2), 32'd7);
        chk("mage_dly7_pulses", 32'(pulses), 32'd1);

        // Two channels on one IV with different delays, then kill ch2 in flight.
        run_dual(1'b0);
        run_dual(1'b1);

        // valid drops for two cycles during RUN -> second start pulse.
        do_reset();
        en[3] = 1'b1; hsel[3] = 2'd3; isel[3] = 2'd0; cons[3] = 8'hFF;
        for (int t = 0; t < 11; t++) begin
            hwlp_valid[3] = !(t == 5 || t == 6);
            #3;
            chk($sformatf("vdrop_start_t%0d", t), 32'(match_d[3]), 32'(t == 1 || t == 8));
            next_cyc();
        end

        // Reset in the middle of a run clears outputs and in-flight pulses.
        do_reset();
        en[0] = 1'b1; hsel[0] = 2'd1; isel[0] = 2'd0; cons[0] = 8'd5;
        en[1] = 1'b1; hsel[1] = 2'd1; isel[1] = 2'd0; cons[1] = 8'd5; mdly[1] = 3'd3;
        hwlp_rf[1][0] = 8'd5;
        hwlp_valid[1] = 1'b1;
        for (int t = 0; t < 4; t++) next_cyc();
        #1;
        chk("midrun_before_reset", 32'(match), 32'h3);
        rst_n_i = 1'b0;
        #1;
        chk("midrun_reset_match_o", 32'(match), 32'd0);
        chk("midrun_reset_match_d_o", 32'(match_d), 32'd0);
        next_cyc();
        hwlp_rf[1][0] = 8'd0;
        rst_n_i = 1'b1;
        pulses = 0;
        for (int t = 0; t < 5; t++) begin
            #3;
            if (match[1]) pulses++;
            next_cyc();
        end
        chk("midrun_inflight_lost", 32'(pulses), 32'd0);

`ifdef ACC_CTRL_MATCH_CNT_EN
        // Saturating counter with CNT_W = 2.
        do_reset();
        en[1] = 1'b1; hsel[1] = 2'd2; isel[1] = 2'd1; cons[1] = 8'd5;
        for (int t = 0; t < 8; t++) begin
            hwlp_rf[2][1] = (t < 5) ? 8'd5 : 8'd0;
            hwlp_valid[2] = 1'b1;
            if (t == 6) en[1] = 1'b0;
            #3;
            if (t == 2) chk("cnt_after_2", 32'(cnt[1]), 32'd2);
            if (t == 5) chk("cnt_saturated", 32'(cnt[1]), 32'd3);
            if (t == 6) chk("cnt_hold_at_disable", 32'(cnt[1]), 32'd3);
            if (t == 7) chk("cnt_cleared", 32'(cnt[1]), 32'd0);
            next_cyc();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
